mcu_mux_sequencer: RTL and testbench
====================================

# mcu_mux_sequencer

Control FSM for the MCU data-select multiplexer array of the 2D convolution engine. Generates the `state` / `substate` / `memSelect` selection codes that steer the mux array, plus the strobes that go with them, for one image strip:
- load N+2 line memories from the host;
- step the convolution substates across every column;
- drain N result words per column.

Sits between the host handshake interface and the mux array / line memories inside the MCU.

## Interface
- `N`, 2, convolution outputs per column; even, ≥2
- `BITS_IMAGEN`, 8, pixel width; carried for package consistency, no data path here
- `STATES`, 3, number of mux-array states; encodes `o_state`
- `IMG_COLS`, 16, columns per strip; ≥2
- `i_clock`  in  1  system clock, rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_start`  in  1  start a strip; honoured only in IDLE
- `i_dataValid`  in  1  host word present (LOAD phase)
- `i_readReady`  in  1  consumer accepts result word (READ phase)
- `o_state`  out  $clog2(STATES)  mux state: 0 LOAD, 1 CONV, 2 READ
- `o_substate`  out  $clog2(N/2+1)+1  convolution substep
- `o_memSelect`  out  $clog2(N+2)  memory/lane select
- `o_colAddr`  out  $clog2(IMG_COLS)  column address to line memories
- `o_dataReady`  out  1  high in LOAD: word will be taken
- `o_memWrite`  out  1  = `i_dataValid & o_dataReady` (combinational)
- `o_convEnable`  out  1  high every CONV cycle
- `o_outValid`  out  1  high in READ: result lane valid
- `o_done`  out  1  one-cycle pulse at strip end

## Operation

FSM states: IDLE, LOAD, CONV, READ. All selection outputs are registered.

**IDLE**
- `o_state` = 0; counters held at 0; all strobes low.
- `i_start` → LOAD.

**LOAD**
- `o_dataReady` = 1.
- Each accepted word (`i_dataValid` high at an edge) advances `o_memSelect` 0..N+1.
- On wrap, `o_colAddr` increments.
- Accepting at `o_colAddr` = IMG_COLS-1 with `o_memSelect` = N+1 → CONV, counters cleared.
- `i_dataValid` low: counters hold, no write.

**CONV**
- `o_state` = 1; `o_convEnable` = 1.
- `o_substate` advances 0..N/2 every cycle, with no stall.
- On wrap, `o_colAddr` increments.
- Last column, `o_substate` = N/2 → READ, counters cleared.
- `o_memSelect` = 0 throughout.

**READ**
- `o_state` = 2; `o_outValid` = 1.
- `o_memSelect` advances 0..N-1 on `i_readReady`; on wrap, `o_colAddr` increments.
- Last lane of last column accepted → IDLE with `o_done` = 1 for that one cycle.

**Boundary conditions**
- `i_start` outside IDLE is ignored.
- `i_start` in the same cycle as `o_done` is ignored; the strip can restart from the next cycle.
- Counters never exceed their terminal values; `o_memSelect` never reaches N in READ.

## Timing
- **Reset** (asynchronous, `i_reset` low): FSM = IDLE and every output = 0, including `o_done`. Reset mid-strip aborts with no `o_done`.
- **Start latency:** `i_start` sampled at edge k → `o_state` = LOAD and `o_dataReady` = 1 after edge k.
- **Handshakes:** both are valid/ready; transfer occurs on an edge with both high. Counter updates are visible the cycle after the transfer.
- **CONV length:** exactly IMG_COLS·(N/2+1) cycles.
- **Strip minimum:** 1 + IMG_COLS·(N+2) + IMG_COLS·(N/2+1) + IMG_COLS·N cycles with host and consumer never stalling. The leading 1 is the IDLE→LOAD edge.
- **Phase boundaries:** `o_state` changes on the same edge as the terminal transfer. No bubble cycles between phases.

## Structure
- **Shared package `mcu_pkg`:**
  - mux state encodings `ST_LOAD` = 0, `ST_CONV` = 1, `ST_READ` = 2 (shared with the mux array);
  - FSM enum including IDLE;
  - width functions for substate, memSelect and column address.
- **One sub-module, `mcu_wrap_counter`:**
  - parameters: MAX, width;
  - ports: `en`, `clr`, `value`, `wrap`;
  - `wrap` = `en` & (`value` == MAX).
- Instantiated three times: memSelect, substate, column. The FSM chains the column counter's enable from the `wrap` outputs.

## Test plan
All scenarios use N=2, IMG_COLS=4.
1. Reset asserted mid-CONV (e.g. column 2) → all outputs 0 immediately. After release, `i_start` begins a clean LOAD with `o_colAddr` = 0.
2. `i_start`, `i_dataValid` held 1, `i_readReady` held 1:
   - 16 `o_memWrite` pulses with `o_memSelect` 0,1,2,3 per column;
   - then 8 CONV cycles with `o_substate` 0,1 per column;
   - then 8 READ cycles with `o_memSelect` 0,1;
   - `o_done` exactly once, 33 cycles after `i_start`.
3. `i_dataValid` toggled 1/0 during LOAD → counters advance only on valid edges. `o_memWrite` count is still 16; LOAD takes 32 cycles.
4. `i_readReady` low for 5 cycles at column 1, lane 1 → `o_memSelect` = 1 and `o_colAddr` = 1 held; `o_outValid` stays 1; completion delayed by 5 cycles.
5. `i_start` pulsed during LOAD, during CONV, and on the `o_done` cycle → no effect; FSM reaches IDLE and `o_done` pulses once.
6. Back-to-back strips with `i_start` the cycle after `o_done` → second strip's sequence is identical to scenario 2.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU mux sequencer and the mux array it drives.
package mcu_pkg;

  // Mux-array state codes; the array decodes these values directly.
  localparam int ST_LOAD = 0;
  localparam int ST_CONV = 1;
  localparam int ST_READ = 2;

  // Sequencer FSM. IDLE has no mux-array code of its own and presents ST_LOAD.
  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_LOAD,
    FSM_CONV,
    FSM_READ
  } fsm_e;

  // Substate counts 0..N/2; the extra bit is kept for the mux array's decode.
  function automatic int substate_w(input int n);
    return $clog2(n / 2 + 1) + 1;
  endfunction

  // Memory select spans the N+2 line memories.
  function automatic int memsel_w(input int n);
    return $clog2(n + 2);
  endfunction

  // Column address spans one strip.
  function automatic int col_w(input int cols);
    return $clog2(cols);
  endfunction

endpackage

// File: rtl/mcu_wrap_counter.sv
// Counter that runs 0..MAX and wraps to 0; flags the wrapping increment.
module mcu_wrap_counter
  import mcu_pkg::*;
#(
  parameter int MAX   = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             at_max;

  assign at_max = (value_q == WIDTH'(MAX));
  assign wrap   = en & at_max;
  assign value  = value_q;

  // Next count: clear has priority, then increment with wrap at MAX.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = at_max ? '0 : value_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/mcu_mux_sequencer.sv
// Strip sequencer for the convolution engine's data-select mux array:
// loads N+2 line memories per column, steps the convolution substates,
// then drains N result lanes per column.
module mcu_mux_sequencer
  import mcu_pkg::*;
#(
  parameter int N           = 2,
  parameter int BITS_IMAGEN = 8,
  parameter int STATES      = 3,
  parameter int IMG_COLS    = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_dataValid,
  input  logic                          i_readReady,
  output logic [$clog2(STATES)-1:0]     o_state,
  output logic [$clog2(N/2+1)+1-1:0]    o_substate,
  output logic [$clog2(N+2)-1:0]        o_memSelect,
  output logic [$clog2(IMG_COLS)-1:0]   o_colAddr,
  output logic                          o_dataReady,
  output logic                          o_memWrite,
  output logic                          o_convEnable,
  output logic                          o_outValid,
  output logic                          o_done
);

  localparam int STATE_W = $clog2(STATES);
  localparam int SUB_W   = substate_w(N);
  localparam int MEM_W   = memsel_w(N);
  localparam int COL_W   = col_w(IMG_COLS);

  // Reject geometries the counters cannot sequence.
  if (N < 2 || (N % 2) != 0 || IMG_COLS < 2 || BITS_IMAGEN < 1 || STATES < 3)
  begin : g_param_check
    $fatal(1, "mcu_mux_sequencer: unsupported parameter set");
  end

  fsm_e fsm_q;
  fsm_e fsm_d;
  logic done_q;
  logic done_d;

  logic [MEM_W-1:0] mem_value;
  logic [SUB_W-1:0] sub_value;
  logic [COL_W-1:0] col_value;
  logic             mem_wrap;
  logic             sub_wrap;
  logic             col_wrap;

  logic in_idle;
  logic load_xfer;
  logic read_xfer;
  logic conv_step;
  logic load_col_done;
  logic lane_last;
  logic col_last;
  logic mem_en;
  logic mem_clr;
  logic col_en;

  assign in_idle   = (fsm_q == FSM_IDLE);
  assign load_xfer = (fsm_q == FSM_LOAD) & i_dataValid;
  assign read_xfer = (fsm_q == FSM_READ) & i_readReady;
  assign conv_step = (fsm_q == FSM_CONV);

  // In LOAD the memSelect counter runs 0..N+1 and wraps by itself; in READ
  // it only runs 0..N-1, so the last lane is detected here and cleared.
  assign load_col_done = mem_wrap & (fsm_q == FSM_LOAD);
  assign lane_last     = read_xfer & (mem_value == MEM_W'(N - 1));
  assign col_last      = (col_value == COL_W'(IMG_COLS - 1));

  assign mem_en  = load_xfer | read_xfer;
  assign mem_clr = lane_last | in_idle;
  assign col_en  = load_col_done | sub_wrap | lane_last;

  mcu_wrap_counter #(
    .MAX   (N + 1),
    .WIDTH (MEM_W)
  ) u_mem_cnt (
    .clk   (i_clock),
    .rst_n (i_reset),
    .en    (mem_en),
    .clr   (mem_clr),
    .value (mem_value),
    .wrap  (mem_wrap)
  );

  mcu_wrap_counter #(
    .MAX   (N / 2),
    .WIDTH (SUB_W)
  ) u_sub_cnt (
    .clk   (i_clock),
    .rst_n (i_reset),
    .en    (conv_step),
    .clr   (in_idle),
    .value (sub_value),
    .wrap  (sub_wrap)
  );

  // Column counter wraps to 0 at each phase end, so no explicit clear is
  // needed between phases; col_wrap is implied by the phase transitions.
  mcu_wrap_counter #(
    .MAX   (IMG_COLS - 1),
    .WIDTH (COL_W)
  ) u_col_cnt (
    .clk   (i_clock),
    .rst_n (i_reset),
    .en    (col_en),
    .clr   (in_idle),
    .value (col_value),
    .wrap  (col_wrap)
  );

  // State and done-pulse registers; reset aborts a strip without o_done.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      fsm_q  <= FSM_IDLE;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      done_q <= done_d;
    end
  end

  // Next state: each phase ends on the terminal transfer of its last column.
  always_comb begin
    fsm_d  = fsm_q;
    done_d = 1'b0;
    unique case (fsm_q)
      FSM_IDLE: begin
        // A start coinciding with the done pulse belongs to the old strip.
        if (i_start && !done_q) begin
          fsm_d = FSM_LOAD;
        end
      end
      FSM_LOAD: begin
        if (load_col_done && col_last) begin
          fsm_d = FSM_CONV;
        end
      end
      FSM_CONV: begin
        if (sub_wrap && col_last) begin
          fsm_d = FSM_READ;
        end
      end
      FSM_READ: begin
        if (lane_last && col_last) begin
          fsm_d  = FSM_IDLE;
          done_d = 1'b1;
        end
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase
    // The column wrap must coincide with a phase end or a column step.
    if (col_wrap && (fsm_d == fsm_q) && !in_idle) begin
      fsm_d = fsm_q;
    end
  end

  // Outputs decode only registered state, so selects are glitch-free
  // relative to the clock except o_memWrite, which follows i_dataValid.
  always_comb begin
    o_state      = STATE_W'(ST_LOAD);
    o_dataReady  = 1'b0;
    o_convEnable = 1'b0;
    o_outValid   = 1'b0;
    unique case (fsm_q)
      FSM_IDLE: o_state = STATE_W'(ST_LOAD);
      FSM_LOAD: begin
        o_state     = STATE_W'(ST_LOAD);
        o_dataReady = 1'b1;
      end
      FSM_CONV: begin
        o_state      = STATE_W'(ST_CONV);
        o_convEnable = 1'b1;
      end
      FSM_READ: begin
        o_state    = STATE_W'(ST_READ);
        o_outValid = 1'b1;
      end
      default: o_state = STATE_W'(ST_LOAD);
    endcase
  end

  assign o_substate  = sub_value;
  assign o_memSelect = mem_value;
  assign o_colAddr   = col_value;
  assign o_memWrite  = i_dataValid & o_dataReady;
  assign o_done      = done_q;

endmodule

// File: tb/tb_mcu_mux_sequencer.sv
// Directed bench for mcu_mux_sequencer with N=2, IMG_COLS=4.
module tb_mcu_mux_sequencer;

  localparam int N    = 2;
  localparam int COLS = 4;

  logic       i_clock;
  logic       i_reset;
  logic       i_start;
  logic       i_dataValid;
  logic       i_readReady;
  logic [1:0] o_state;
  logic [1:0] o_substate;
  logic [1:0] o_memSelect;
  logic [1:0] o_colAddr;
  logic       o_dataReady;
  logic       o_memWrite;
  logic       o_convEnable;
  logic       o_outValid;
  logic       o_done;

  int n_vec;
  int n_err;

  mcu_mux_sequencer #(
    .N           (N),
    .BITS_IMAGEN (8),
    .STATES      (3),
    .IMG_COLS    (COLS)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_dataValid  (i_dataValid),
    .i_readReady  (i_readReady),
    .o_state      (o_state),
    .o_substate   (o_substate),
    .o_memSelect  (o_memSelect),
    .o_colAddr    (o_colAddr),
    .o_dataReady  (o_dataReady),
    .o_memWrite   (o_memWrite),
    .o_convEnable (o_convEnable),
    .o_outValid   (o_outValid),
    .o_done       (o_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_sub"}, o_substate, 0);
    check({tag, "_sel"}, o_memSelect, 0);
    check({tag, "_col"}, o_colAddr, 0);
    check({tag, "_rdy"}, o_dataReady, 0);
    check({tag, "_wr"}, o_memWrite, 0);
    check({tag, "_cen"}, o_convEnable, 0);
    check({tag, "_ov"}, o_outValid, 0);
    check({tag, "_done"}, o_done, 0);
  endtask

  // One full strip from IDLE; ends in the cycle after the done pulse.
  task automatic run_strip(input bit dv_toggle, input bit stall, input bit pulses,
                           input int exp_cycles);
    int cyc;
    int wr;
    cyc = 0;
    wr  = 0;
    i_dataValid = 1'b0;
    i_readReady = 1'b1;
    #1;
    check("idle_rdy", o_dataReady, 0);
    check("idle_done", o_done, 0);
    i_start = 1'b1;
    tick(); cyc++;
    i_start = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      for (int m = 0; m < N + 2; m++) begin
        if (dv_toggle) begin
          i_dataValid = 1'b0;
          #1;
          check("ld_hold_sel", o_memSelect, m);
          check("ld_hold_col", o_colAddr, c);
          check("ld_hold_wr", o_memWrite, 0);
          tick(); cyc++;
        end
        i_dataValid = 1'b1;
        i_start = pulses && c == 1 && m == 2;
        #1;
        check("ld_state", o_state, 0);
        check("ld_rdy", o_dataReady, 1);
        check("ld_sel", o_memSelect, m);
        check("ld_col", o_colAddr, c);
        wr += int'(o_memWrite);
        tick(); cyc++;
        i_start = 1'b0;
      end
    end
    i_dataValid = 1'b0;
    check("ld_writes", wr, 16);
    for (int c = 0; c < COLS; c++) begin
      for (int s = 0; s <= N / 2; s++) begin
        i_start = pulses && c == 2 && s == 0;
        #1;
        check("cv_state", o_state, 1);
        check("cv_en", o_convEnable, 1);
        check("cv_sub", o_substate, s);
        check("cv_sel", o_memSelect, 0);
        check("cv_col", o_colAddr, c);
        check("cv_rdy", o_dataReady, 0);
        tick(); cyc++;
        i_start = 1'b0;
      end
    end
    for (int c = 0; c < COLS; c++) begin
      for (int l = 0; l < N; l++) begin
        if (stall && c == 1 && l == 1) begin
          i_readReady = 1'b0;
          for (int k = 0; k < 5; k++) begin
            #1;
            check("rd_stall_sel", o_memSelect, 1);
            check("rd_stall_col", o_colAddr, 1);
            check("rd_stall_ov", o_outValid, 1);
            tick(); cyc++;
          end
          i_readReady = 1'b1;
        end
        #1;
        check("rd_state", o_state, 2);
        check("rd_ov", o_outValid, 1);
        check("rd_sel", o_memSelect, l);
        check("rd_col", o_colAddr, c);
        check("rd_done", o_done, 0);
        tick(); cyc++;
      end
    end
    #1;
    check("end_done", o_done, 1);
    check("end_state", o_state, 0);
    check("end_ov", o_outValid, 0);
    check("end_cycles", cyc, exp_cycles);
    if (pulses) i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("post_done", o_done, 0);
    check("post_rdy", o_dataReady, 0);
    check("post_col", o_colAddr, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    i_reset = 1'b0;
    i_start = 1'b0;
    i_dataValid = 1'b0;
    i_readReady = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    i_reset = 1'b1;
    tick();
    check_all_zero("idle");

    // Nominal strip, no stalls.
    run_strip(1'b0, 1'b0, 1'b0, 33);

    // Reset in CONV column 2, then a clean strip.
    i_dataValid = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 16 + 4; k++) tick();
    check("ab_state", o_state, 1);
    check("ab_col", o_colAddr, 2);
    #2;
    i_reset = 1'b0;
    #1;
    check_all_zero("ab_rst");
    tick();
    check_all_zero("ab_hold");
    i_reset = 1'b1;
    i_dataValid = 1'b0;
    tick();
    check_all_zero("ab_idle");
    run_strip(1'b0, 1'b0, 1'b0, 33);

    // Host toggling valid.
    run_strip(1'b1, 1'b0, 1'b0, 49);

    // Consumer stall at column 1, lane 1.
    run_strip(1'b0, 1'b1, 1'b0, 38);

    // Stray starts in LOAD, CONV and on the done cycle.
    run_strip(1'b0, 1'b0, 1'b1, 33);

    // Back-to-back strips.
    run_strip(1'b0, 1'b0, 1'b0, 33);
    run_strip(1'b0, 1'b0, 1'b0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
